// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: unsigned 8x8 -> 16-bit multiplier built from one
// combinational 4x4 array multiplier reused over four cycles, with
// valid/ready handshakes on the operand and result sides.

module mul4x4_array (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  // Sum of the four AND-gated partial-product rows, row i weighted by 2^i
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      p = p + ({4'b0000, x & {4{y[i]}}} << i);
    end
  end

endmodule

module mul8_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [7:0]  ra;
  logic [7:0]  rb;
  logic [15:0] acc;
  logic [1:0]  step;

  logic [3:0]  mul_x;
  logic [3:0]  mul_y;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic [15:0] acc_next;
  logic        accept;
  logic        handoff;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign handoff  = out_valid & out_ready;
  assign busy     = (state == MUL);

  mul4x4_array u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (pp)
  );

  // Pick the nibble pair for this step and weight its partial product:
  // step bit 0 selects the high nibble of ra, bit 1 the high nibble of rb
  always_comb begin
    mul_x = step[0] ? ra[7:4] : ra[3:0];
    mul_y = step[1] ? rb[7:4] : rb[3:0];
    case (step)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd3:    pp_shifted = {pp, 8'h00};
      default: pp_shifted = {4'h0, pp, 4'h0};
    endcase
    acc_next = acc + pp_shifted;
  end

  // Handshake FSM, operand capture, accumulation and result hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= '0;
      rb        <= '0;
      acc       <= '0;
      step      <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ra    <= a;
            rb    <= b;
            acc   <= '0;
            step  <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            product   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (handoff) begin
            op_count  <= op_count + CNT_ONE;
            out_valid <= 1'b0;
            if (accept) begin
              ra    <= a;
              rb    <= b;
              acc   <= '0;
              step  <= '0;
              state <= MUL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: directed and randomized checks of the sequential
// 8x8 multiplier controller with hand-computed expected products.

module tb_mul8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;
  logic [7:0]  op_count;

  int testsRun = 0;
  int testsFailed = 0;
  int expCount = 0;

  mul8_seq_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expCount = 0;
  endtask

  // Accept one operand pair from IDLE and check the exact 4-cycle latency
  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                               input logic [15:0] exp, input string tag);
    a = va;
    b = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checkOutput({tag, " busy"}, busy, 1'b1);
      checkOutput({tag, " early valid"}, out_valid, 1'b0);
      tick();
    end
    checkOutput({tag, " out_valid"}, out_valid, 1'b1);
    checkOutput({tag, " busy done"}, busy, 1'b0);
    checkOutput({tag, " product"}, product, exp);
  endtask

  // Hand the pending result to the sink with no new operand offered
  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    expCount = (expCount + 1) % 256;
    checkOutput({tag, " valid cleared"}, out_valid, 1'b0);
    checkOutput({tag, " in_ready idle"}, in_ready, 1'b1);
    checkOutput({tag, " op_count"}, op_count, expCount);
  endtask

  logic [7:0]  b2bA [3];
  logic [7:0]  b2bB [3];
  logic [15:0] b2bP [3];
  logic [15:0] expQ [$];

  initial begin
    int n;
    int sent;
    int recv;
    int cycles;
    logic fireIn;
    logic fireOut;
    logic [15:0] expP;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    b2bA = '{8'h12, 8'hFF, 8'h9C};
    b2bB = '{8'h34, 8'h01, 8'h07};
    b2bP = '{16'h03A8, 16'h00FF, 16'h0444};

    applyReset();
    checkOutput("reset in_ready", in_ready, 1'b1);
    checkOutput("reset out_valid", out_valid, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset product", product, 16'h0000);
    checkOutput("reset op_count", op_count, 8'h00);

    applyStimulus(8'h12, 8'h34, 16'h03A8, "basic");
    handoff("basic");
    checkOutput("basic product kept", product, 16'h03A8);

    applyStimulus(8'hFF, 8'hFF, 16'hFE01, "ffxff");
    handoff("ffxff");
    applyStimulus(8'h00, 8'hA5, 16'h0000, "zero");
    handoff("zero");
    applyStimulus(8'h80, 8'h02, 16'h0100, "80x02");
    handoff("80x02");
    applyStimulus(8'h0F, 8'hF0, 16'h0E10, "0fxf0");
    handoff("0fxf0");

    applyStimulus(8'h37, 8'h5B, 16'h138D, "bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp product", product, 16'h138D);
      checkOutput("bp out_valid", out_valid, 1'b1);
      checkOutput("bp in_ready", in_ready, 1'b0);
    end
    checkOutput("bp op_count held", op_count, expCount);
    handoff("bp");

    a = b2bA[0];
    b = b2bB[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
      checkOutput("b2b latency", n, 4);
      checkOutput("b2b product", product, b2bP[r]);
      checkOutput("b2b in_ready", in_ready, 1'b1);
      if (r < 2) begin
        a = b2bA[r + 1];
        b = b2bB[r + 1];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      expCount = (expCount + 1) % 256;
      checkOutput("b2b valid drop", out_valid, 1'b0);
      checkOutput("b2b busy", busy, (r < 2) ? 1'b1 : 1'b0);
    end
    out_ready = 1'b0;
    checkOutput("b2b op_count", op_count, expCount);

    a = 8'hAA;
    b = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expCount = 0;
    checkOutput("abort out_valid", out_valid, 1'b0);
    checkOutput("abort product", product, 16'h0000);
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort in_ready", in_ready, 1'b1);
    checkOutput("abort op_count", op_count, 8'h00);
    tick();
    checkOutput("abort stays idle", out_valid, 1'b0);
    applyStimulus(8'h03, 8'h04, 16'h000C, "after abort");
    handoff("after abort");

    applyReset();
    sent = 0;
    recv = 0;
    cycles = 0;
    while (recv < 1000 && cycles < 30000) begin
      out_ready = ($urandom_range(3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(2) != 0) begin
        in_valid = 1'b1;
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
      end
      #1;
      fireIn = in_valid & in_ready;
      fireOut = out_valid & out_ready;
      if (fireOut) begin
        expP = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        checkOutput("sweep product", product, expP);
        recv++;
      end
      if (fireIn) begin
        expQ.push_back(16'(a) * 16'(b));
        sent++;
      end
      tick();
      cycles++;
      if (fireIn) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checkOutput("sweep completed", recv, 1000);
    checkOutput("sweep op_count", op_count, 8'hE8);
    expCount = 232;

    for (int i = 0; i < 24; i++) begin
      a = 8'(i * 11 + 3);
      b = 8'(255 - i * 7);
      expP = 16'(a) * 16'(b);
      applyStimulus(a, b, expP, "wrap");
      handoff("wrap");
    end
    checkOutput("wrap op_count zero", op_count, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
